// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 frame receiver.
package ps2_pkg;
  localparam int PS2_DATA_BITS = 8;
  localparam int PS2_FRAME_BITS = 11;
  typedef logic [PS2_DATA_BITS-1:0] ps2_byte_t;
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, DATA, PARITY, STOP} ps2_state_e;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: two-flop synchroniser followed by a run-length deglitch filter.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic s1_q, s2_q, filt_q;
  logic [CW-1:0] cnt_q;
  // The filtered line flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      filt_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q <= line_i;
      s2_q <= s1_q;
      if (s2_q == filt_q) cnt_q <= '0;
      else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= s2_q;
        cnt_q <= '0;
      end else cnt_q <= cnt_q + CW'(1);
    end
  end
  assign line_o = filt_q;
endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: frames PS/2 packets on the system clock and emits checked scan-code bytes.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int IDLE_CYCLES = 5000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ps2_clk,
  input  logic      ps2_data,
  output ps2_byte_t byte_out,
  output logic      byte_valid,
  output logic      parity_err,
  output logic      frame_err,
  output logic      busy
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  logic clk_f, dat_f;
  logic clk_prev_q, fall_q, bit_q;
  ps2_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  ps2_byte_t shift_q, shift_d, byte_q, byte_d;
  logic par_q, par_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [IW-1:0] idle_q, idle_d;
  logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .line_i(ps2_clk), .line_o(clk_f)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk), .rst(rst), .line_i(ps2_data), .line_o(dat_f)
  );
  // Both filters have equal delay, so the data bit registered with the fall is aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q <= 1'b1;
      fall_q <= 1'b0;
      bit_q <= 1'b1;
    end else begin
      clk_prev_q <= clk_f;
      fall_q <= clk_prev_q & ~clk_f;
      bit_q <= dat_f;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    shift_d = shift_q;
    par_d = par_q;
    byte_d = byte_q;
    busy_d = busy_q;
    wd_d = '0;
    idle_d = '0;
    valid_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        busy_d = 1'b0;
        idle_d = clk_f ? idle_q + IW'(1) : '0;
        if (idle_q == IW'(IDLE_CYCLES - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (fall_q && !bit_q) begin
          state_d = DATA;
          idx_d = '0;
          shift_d = '0;
          busy_d = 1'b1;
        end else if (fall_q) begin
          ferr_d = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        wd_d = fall_q ? '0 : wd_q + WW'(1);
        if (!fall_q && wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          ferr_d = 1'b1;
          busy_d = 1'b0;
          wd_d = '0;
          state_d = WAIT_IDLE;
        end else if (fall_q) begin
          case (state_q)
            DATA: begin
              shift_d[idx_q] = bit_q;
              idx_d = idx_q + 3'd1;
              if (idx_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
            end
            PARITY: begin
              par_d = bit_q;
              state_d = STOP;
            end
            default: begin
              busy_d = 1'b0;
              state_d = IDLE;
              if (!bit_q) ferr_d = 1'b1;
              else if (!(^{shift_q, par_q})) perr_d = 1'b1;
              else begin
                byte_d = shift_q;
                valid_d = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_IDLE;
      idx_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      byte_q <= '0;
      busy_q <= 1'b0;
      wd_q <= '0;
      idle_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      par_q <= par_d;
      byte_q <= byte_d;
      busy_q <= busy_d;
      wd_q <= wd_d;
      idle_q <= idle_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end
  assign byte_out = byte_q;
  assign byte_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err = ferr_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: scoreboard bench driving scaled-down PS/2 frames into ps2_frame_rx.
module tb_ps2_frame_rx;
  localparam int F = 8;
  localparam int T = 400;
  localparam int I = 50;
  localparam int H = 40;
  localparam int GAP = 120;
  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_PERR = 3'b010;
  localparam logic [2:0] K_FERR = 3'b100;
  typedef struct packed {logic [2:0] kind; logic [7:0] b;} ev_t;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] byte_out;
  logic byte_valid, parity_err, frame_err, busy;
  ev_t q[$];
  ev_t e;
  int n_chk = 0, n_err = 0, cyc = 0, ferr_cyc = -1, last_fall = 0, d = 0;
  logic [7:0] last_b = 8'h00;
  logic [10:0] f;
  ps2_frame_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T), .IDLE_CYCLES(I)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && (byte_valid || parity_err || frame_err)) begin
      if (frame_err) ferr_cyc = cyc;
      if (q.size() == 0) check("unexpected strobe", {29'd0, frame_err, parity_err, byte_valid}, 0);
      else begin
        e = q.pop_front();
        check("strobe kind", {29'd0, frame_err, parity_err, byte_valid}, {29'd0, e.kind});
        if (e.kind == K_VALID) last_b = e.b;
        check("byte_out", {24'd0, byte_out}, {24'd0, last_b});
      end
    end
  end
  function automatic logic [10:0] frame(input logic [7:0] b, input logic par_flip, input logic stop);
    return {stop, ~^b ^ par_flip, b, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] fr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = fr[i];
      repeat (H / 2) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (H / 2) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input logic par_flip, input logic stop, input logic [2:0] kind);
    q.push_back('{kind: kind, b: b});
    send_bits(frame(b, par_flip, stop), 0, 10);
    repeat (GAP) @(negedge clk);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
    check(tag, q.size(), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("reset byte_out", {24'd0, byte_out}, 0);
    check("reset strobes/busy", {28'd0, byte_valid, parity_err, frame_err, busy}, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    send(8'h1C, 1'b0, 1'b1, K_VALID);
    drain("t1 drain");
    send(8'hF0, 1'b0, 1'b1, K_VALID);
    send(8'h1C, 1'b0, 1'b1, K_VALID);
    drain("t2 drain");
    send(8'h1C, 1'b1, 1'b1, K_PERR);
    send(8'hE0, 1'b0, 1'b1, K_VALID);
    drain("t3 drain");
    send(8'h1C, 1'b0, 1'b0, K_FERR);
    drain("t4 drain");
    q.push_back('{kind: K_FERR, b: 8'h00});
    ferr_cyc = -1;
    send_bits(frame(8'hA5, 1'b0, 1'b1), 0, 4);
    check("busy mid-frame", {31'd0, busy}, 1);
    for (int i = 0; i < T + 100 && ferr_cyc < 0; i++) @(negedge clk);
    d = ferr_cyc - last_fall;
    check("timeout delay", d, F + T + 4);
    check("busy after timeout", {31'd0, busy}, 0);
    repeat (GAP) @(negedge clk);
    send(8'hF0, 1'b0, 1'b1, K_VALID);
    drain("t5 drain");
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    check("busy after glitch", {31'd0, busy}, 0);
    send(8'h1C, 1'b0, 1'b1, K_VALID);
    drain("glitch drain");
    f = frame(8'h5A, 1'b0, 1'b1);
    send_bits(f, 0, 4);
    rst = 1'b1;
    last_b = 8'h00;
    repeat (2) @(negedge clk);
    check("mid-rst byte_out", {24'd0, byte_out}, 0);
    check("mid-rst busy", {31'd0, busy}, 0);
    rst = 1'b0;
    send_bits(f, 5, 10);
    repeat (GAP) @(negedge clk);
    send(8'hE0, 1'b0, 1'b1, K_VALID);
    drain("t6 drain");
    check("final byte_out", {24'd0, byte_out}, 32'hE0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
